// File: rtl/pipe_mux.sv
// pipe_mux: registered N-to-1 channel select with valid/ready handshake on both sides.
// Define PIPE_MUX_SKID_EN for a 2-entry skid buffer with a registered in_ready.
module pipe_mux #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 6,
    parameter int SEL_W  = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] din,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        dout,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sel_err,
    input  logic                    err_clr
);

    logic [WIDTH-1:0] cap_data;
    logic             sel_ok;
    logic             in_xfer;
    logic             main_open;

    // Out-of-range selects fall through to channel 0 and leave sel_ok low.
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        cap_data = din[WIDTH-1:0];
        sel_ok   = 1'b0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                cap_data = din[k*WIDTH +: WIDTH];
                sel_ok   = 1'b1;
            end
        end
    end

    assign in_xfer   = in_valid && in_ready;
    assign main_open = !out_valid || out_ready;

    // Set has priority over clear so a concurrent bad select is never lost.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_err <= 1'b0;
        end else if (in_xfer && !sel_ok) begin
            sel_err <= 1'b1;
        end else if (err_clr) begin
            sel_err <= 1'b0;
        end
    end

`ifdef PIPE_MUX_SKID_EN
    logic [WIDTH-1:0] skid_data;
    logic             skid_valid;
    logic             skid_valid_nxt;
    logic             rdy_q;

    assign in_ready = rdy_q;

    // in_xfer cannot coincide with a full skid entry because rdy_q tracks its emptiness.
    always_comb begin
        skid_valid_nxt = skid_valid;
        if (main_open) begin
            skid_valid_nxt = 1'b0;
        end else if (in_xfer) begin
            skid_valid_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            dout       <= '0;
            skid_valid <= 1'b0;
            rdy_q      <= 1'b0;
        end else begin
            skid_valid <= skid_valid_nxt;
            rdy_q      <= !skid_valid_nxt;
            if (main_open) begin
                if (skid_valid) begin
                    dout      <= skid_data;
                    out_valid <= 1'b1;
                end else begin
                    out_valid <= in_xfer;
                    if (in_xfer) begin
                        dout <= cap_data;
                    end
                end
            end
        end
    end

    // NOTE: the skid payload is not reset; skid_valid alone decides whether it is ever used.
    always_ff @(posedge clk) begin
        if (!main_open && in_xfer) begin
            skid_data <= cap_data;
        end
    end
`else
    // Reset gating keeps upstream from seeing a ready while the stage is being flushed.
    assign in_ready = !rst && main_open;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            dout      <= '0;
        end else if (main_open) begin
            out_valid <= in_xfer;
            if (in_xfer) begin
                dout <= cap_data;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_mux.sv
// Directed self-checking bench for pipe_mux (NUM_IN=6, WIDTH=32), either buffering mode.
// Build with PIPE_MUX_SKID_EN defined to exercise the skid-buffer expectations.
module tb_pipe_mux;

    localparam int WIDTH  = 32;
    localparam int NUM_IN = 6;
    localparam int SEL_W  = 3;

`ifdef PIPE_MUX_SKID_EN
    localparam int STALL_EXTRA = 1;
`else
    localparam int STALL_EXTRA = 0;
`endif

    logic                    clk;
    logic                    rst;
    logic [NUM_IN*WIDTH-1:0] din;
    logic [SEL_W-1:0]        sel;
    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        dout;
    logic                    out_valid;
    logic                    out_ready;
    logic                    sel_err;
    logic                    err_clr;

    int checks = 0;
    int errors = 0;

    pipe_mux #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dout      (dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sel_err   (sel_err),
        .err_clr   (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] chan [NUM_IN] = '{32'hA000_0000, 32'hA111_1111, 32'hA222_2222,
                                   32'hA333_3333, 32'hA444_4444, 32'hA555_5555};
    logic [31:0] exp_q [$];
    logic [31:0] exp_head;
    int          next_in;
    int          delivered;
    int          stall_acc;
    logic        acc;

    initial begin
        rst = 1'b1; din = '0; sel = '0; in_valid = 1'b0; out_ready = 1'b1; err_clr = 1'b0;

        // Reset state
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_dout", dout, 0);
        check("rst_sel_err", sel_err, 0);
        check("rst_in_ready", in_ready, 0);

        // Basic capture, channel 3, latency 1
        tick();
        rst = 1'b0;
        tick();
        din[3*WIDTH +: WIDTH] = 32'hDEAD_BEEF;
        sel = 3'd3; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        check("rel_in_ready", in_ready, 1);
        check("rel_out_valid", out_valid, 0);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("cap3_valid", out_valid, 1);
        check("cap3_dout", dout, 32'hDEAD_BEEF);
        check("cap3_err", sel_err, 0);
        tick();
        @(negedge clk);
        check("drain_valid", out_valid, 0);

        // Out-of-range select, sticky error, clear, set-wins
        tick();
        din[0 +: WIDTH] = 32'h1234_5678;
        sel = 3'd6; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("bad_sel_dout", dout, 32'h1234_5678);
        check("bad_sel_valid", out_valid, 1);
        check("bad_sel_err", sel_err, 1);
        tick();
        @(negedge clk);
        check("err_sticky", sel_err, 1);
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        @(negedge clk);
        check("err_cleared", sel_err, 0);
        tick();
        sel = 3'd7; in_valid = 1'b0;
        tick();
        @(negedge clk);
        check("idle_sel_no_err", sel_err, 0);
        check("idle_sel_no_valid", out_valid, 0);
        tick();
        din[0 +: WIDTH] = 32'h0BAD_F00D;
        sel = 3'd7; in_valid = 1'b1; err_clr = 1'b1;
        tick();
        in_valid = 1'b0; err_clr = 1'b0;
        @(negedge clk);
        check("set_wins_err", sel_err, 1);
        check("set_wins_dout", dout, 32'h0BAD_F00D);
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

        // Back-to-back stream sel=0..5
        for (int k = 0; k < NUM_IN; k++) din[k*WIDTH +: WIDTH] = chan[k];
        for (int i = 0; i <= NUM_IN; i++) begin
            if (i < NUM_IN) begin
                sel = SEL_W'(i);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (i > 0) begin
                check("stream_valid", out_valid, 1);
                check("stream_dout", dout, chan[i-1]);
            end
            if (i < NUM_IN) check("stream_rdy", in_ready, 1);
            tick();
        end

        // Stall mid-stream for 4 cycles; unique payload per beat
        next_in = 0; delivered = 0; stall_acc = 0;
        for (int c = 0; c < 40; c++) begin
            if (next_in < 8) begin
                in_valid = 1'b1;
                sel = SEL_W'(next_in % NUM_IN);
                for (int k = 0; k < NUM_IN; k++) din[k*WIDTH +: WIDTH] = 32'hFFFF_0000 | k;
                din[(next_in % NUM_IN)*WIDTH +: WIDTH] = 32'hB000_0000 + next_in;
            end else begin
                in_valid = 1'b0;
            end
            out_ready = !(c >= 3 && c <= 6);
            @(negedge clk);
            acc = in_valid && in_ready;
            if (c >= 3 && c <= 6) begin
                exp_head = (exp_q.size() > 0) ? exp_q[0] : 32'hFFFF_FFFF;
                check("stall_valid", out_valid, 1);
                check("stall_hold", dout, exp_head);
                if (acc) stall_acc++;
            end
            if (c == 3) check("stall_rdy_first", in_ready, STALL_EXTRA);
            if (c == 6) check("stall_rdy_last", in_ready, 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_beat", out_valid, 0);
                end else begin
                    check("stall_order", dout, exp_q[0]);
                    void'(exp_q.pop_front());
                    delivered++;
                end
            end
            tick();
            if (acc) begin
                exp_q.push_back(32'hB000_0000 + next_in);
                next_in++;
            end
            if (next_in == 8 && exp_q.size() == 0) break;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("stall_extra_beats", stall_acc, STALL_EXTRA);
        check("stall_delivered", delivered, 8);

        // Reset while stalled: held beat(s) and error flag discarded
        tick();
        for (int k = 0; k < NUM_IN; k++) din[k*WIDTH +: WIDTH] = '0;
        din[0 +: WIDTH] = 32'h5A5A_5A5A;
        sel = 3'd6; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_valid", out_valid, 1);
        check("pre_rst_dout", dout, 32'h5A5A_5A5A);
        check("pre_rst_err", sel_err, 1);
        tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_dout", dout, 0);
        check("mid_rst_err", sel_err, 0);
        check("mid_rst_rdy", in_ready, 0);
        tick();
        rst = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_stale_beat", out_valid, 0);
            tick();
        end
        @(negedge clk);
        check("post_rst_rdy", in_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
